program_rom_loader: RTL and testbench
=====================================

# program_rom_loader

Parametrised, synchronous-read instruction memory for the processor core, with a built-in byte-stream loader so programs are written at run time instead of being hard-coded. The fetch stage reads one instruction word per request with one-cycle latency. A load FSM assembles incoming bytes into words and writes them to a contiguous, wrapping address range. Words never written since reset read back as a programmable default instruction.

## Interface
- `ADDR_WIDTH`, 10, word-address width; depth = 2**ADDR_WIDTH words.
- `DATA_WIDTH`, 32, instruction width; must be a multiple of 8. BYTES = DATA_WIDTH/8.
- `DEFAULT_WORD`, 0, value returned for any word not written since reset.

- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `iAddress` in ADDR_WIDTH: fetch word address.
- `iReadEnable` in 1: fetch request.
- `oInstruction` out DATA_WIDTH: registered fetch data.
- `oValid` out 1: `oInstruction` is valid for the request from the previous cycle.
- `iLoadStart` in 1: start a load; sampled only in IDLE.
- `iLoadBase` in ADDR_WIDTH: first word address of the load.
- `iLoadCount` in ADDR_WIDTH+1: number of words to load; 0..2**ADDR_WIDTH.
- `iByte` in 8: load data byte.
- `iByteValid` in 1: `iByte` is offered.
- `oByteReady` out 1: the loader accepts a byte this cycle.
- `oLoading` out 1: a load is in progress (any state other than IDLE).
- `oLoadDone` out 1: one-cycle pulse when a load completes.

## Operation
- **Storage:** DEPTH×DATA_WIDTH array plus a DEPTH-bit written-flag vector. Reset clears all flags; array contents are not reset.
- **Fetch:**
  - Accepted when `iReadEnable`=1 and the FSM is in IDLE.
  - The next cycle, `oValid`=1 and `oInstruction` = mem[iAddress] if the flag is set, else DEFAULT_WORD.
  - Requests while `oLoading`=1 are dropped: `oValid`=0 next cycle and `oInstruction` holds its last value. The core must stall while loading.
- **FSM states:** IDLE, LOAD, WRITE, DONE.
  - **IDLE:** if `iLoadStart`, latch base into the write pointer and count into the remaining counter. Go to DONE if the count is 0, else LOAD. Byte counter is cleared.
  - **LOAD:** `oByteReady`=1. A handshake (`iByteValid` && `oByteReady`) shifts the byte into the word register, big-endian: the first byte goes to the MSBs (opcode first). When the BYTES-th byte is accepted, go to WRITE.
  - **WRITE:** `oByteReady`=0. Write the word at the pointer, set its flag, increment the pointer modulo DEPTH, and decrement remaining. Go to DONE if remaining becomes 0, else LOAD.
  - **DONE:** `oLoadDone`=1 for this cycle only; go to IDLE.
- `iLoadStart` outside IDLE is ignored.
- `iByteValid` outside LOAD is ignored; no byte is consumed.
- **Wrap-around:** addresses past DEPTH-1 continue at 0. A count of 2**ADDR_WIDTH fills the whole memory. Overlapping words are overwritten in order.
- **Reset mid-load:** FSM returns to IDLE, partial word is discarded, all flags clear, and all outputs return to their reset values.

## Timing
- **Reset values:** `oInstruction`=0, `oValid`=0, `oByteReady`=0, `oLoading`=0, `oLoadDone`=0.
- **Fetch latency:** 1 cycle; full throughput of one request per cycle in IDLE.
- **`iLoadStart` at cycle t:**
  - `oLoading`=1 from t+1.
  - `oByteReady`=1 from t+1 when the count is nonzero.
- **Word cost:** with bytes offered every cycle, each word takes BYTES LOAD cycles plus 1 WRITE cycle. An N-word load has `oLoadDone` at t+1+N·(BYTES+1); `oLoading` falls the cycle after.
- **Zero-count load:** `oLoadDone` at t+1, with no write.
- **Loaded data visibility:** a word written in WRITE is visible to the first fetch accepted after returning to IDLE.

## Test plan
1. **Reset then default read:** reset, then fetch addr 5 → next cycle `oValid`=1, `oInstruction`=DEFAULT_WORD; fetch with `iReadEnable`=0 → `oValid`=0.
2. **Two-word load:** load base 3, count 2, bytes 01..08 back-to-back → `oLoadDone` at t+11. Fetch 3 → 0x01020304; fetch 4 → 0x05060708; fetch 5 → DEFAULT_WORD.
3. **Wrap-around:** load base 1023, count 2, bytes AA BB CC DD 11 22 33 44 → addr 1023 = 0xAABBCCDD, addr 0 = 0x11223344.
4. **Byte gaps:** `iByteValid` toggled 1/0 during a 1-word load → only handshaken bytes are taken; word is correct; done is delayed by the gap cycles.
5. **Fetch during load and zero-count load:** fetch while `oLoading`=1 → `oValid`=0, `oInstruction` unchanged. `iLoadStart` with count 0 → `oLoadDone` the next cycle and no flags set. `iLoadStart` mid-load → ignored.
6. **Reset mid-load:** `Reset` asserted after 2 bytes of a word → all outputs at reset values; previously loaded addr 3 reads DEFAULT_WORD; a new load works normally.

Source files
------------

// File: rtl/program_rom_loader.sv
// Synchronous-read instruction memory with a byte-stream program loader.
// Unwritten words (tracked by a per-word flag cleared on reset) read as DEFAULT_WORD.
module program_rom_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    input  logic                  iReadEnable,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oValid,
    input  logic                  iLoadStart,
    input  logic [ADDR_WIDTH-1:0] iLoadBase,
    input  logic [ADDR_WIDTH:0]   iLoadCount,
    input  logic [7:0]            iByte,
    input  logic                  iByteValid,
    output logic                  oByteReady,
    output logic                  oLoading,
    output logic                  oLoadDone
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]        written;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH:0]     remaining;
    logic [BCW-1:0]          byte_cnt;
    logic [DATA_WIDTH-1:0]   word_reg;
    logic                    handshake;
    logic                    last_byte;

    always_comb begin
        handshake = (state == LOAD) && iByteValid;
        last_byte = (byte_cnt == BCW'(BYTES - 1));
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (iLoadStart) state_next = (iLoadCount == '0) ? DONE : LOAD;
            LOAD:    if (handshake && last_byte) state_next = WRITE;
            WRITE:   state_next = (remaining == (ADDR_WIDTH + 1)'(1)) ? DONE : LOAD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        oByteReady = (state == LOAD);
        oLoading   = (state != IDLE);
        oLoadDone  = (state == DONE);
    end

    // Loader datapath: bytes shift in from the LSB end so the first byte ends up in the MSBs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr    <= '0;
            remaining <= '0;
            byte_cnt  <= '0;
            word_reg  <= '0;
            written   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    byte_cnt <= '0;
                    if (iLoadStart) begin
                        wr_ptr    <= iLoadBase;
                        remaining <= iLoadCount;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        word_reg <= (word_reg << 8) | DATA_WIDTH'(iByte);
                        byte_cnt <= last_byte ? '0 : byte_cnt + BCW'(1);
                    end
                end
                WRITE: begin
                    written[wr_ptr] <= 1'b1;
                    wr_ptr          <= wr_ptr + ADDR_WIDTH'(1);
                    remaining       <= remaining - (ADDR_WIDTH + 1)'(1);
                    byte_cnt        <= '0;
                end
                default: ;
            endcase
        end
    end

    // Array itself has no reset so it can map onto block RAM.
    always_ff @(posedge Clock) begin
        if (!Reset && state == WRITE) begin
            mem[wr_ptr] <= word_reg;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oValid       <= 1'b0;
            oInstruction <= '0;
        end else if (state == IDLE && iReadEnable) begin
            oValid       <= 1'b1;
            oInstruction <= written[iAddress] ? mem[iAddress] : DEFAULT_WORD;
        end else begin
            oValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_program_rom_loader.sv
// Directed bench for program_rom_loader: queue-based transaction model checked every cycle,
// plus hand-computed literal expectations for data and load timing.
module tb_program_rom_loader;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int BY    = DW / 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] DEF = 32'hDEAD_BEEF;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] iAddress = '0;
    logic          iReadEnable = 1'b0;
    logic [DW-1:0] oInstruction;
    logic          oValid;
    logic          iLoadStart = 1'b0;
    logic [AW-1:0] iLoadBase = '0;
    logic [AW:0]   iLoadCount = '0;
    logic [7:0]    iByte = '0;
    logic          iByteValid = 1'b0;
    logic          oByteReady;
    logic          oLoading;
    logic          oLoadDone;

    program_rom_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEFAULT_WORD(DEF)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iAddress(iAddress),
        .iReadEnable(iReadEnable),
        .oInstruction(oInstruction),
        .oValid(oValid),
        .iLoadStart(iLoadStart),
        .iLoadBase(iLoadBase),
        .iLoadCount(iLoadCount),
        .iByte(iByte),
        .iByteValid(iByteValid),
        .oByteReady(oByteReady),
        .oLoading(oLoading),
        .oLoadDone(oLoadDone)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge Clock) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a load is a job that collects bytes into a queue; a full queue costs one
    // cycle to commit, and the job ends with a single completion cycle.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_flag [DEPTH];
    logic [7:0]    m_q [$];
    bit            m_init = 0;
    bit            m_busy, m_done, m_valid;
    logic [DW-1:0] m_instr;
    int            m_left, m_ptr;

    always @(posedge Clock) begin
        if (Reset) begin
            m_init = 1;
            m_busy = 0;
            m_done = 0;
            m_valid = 0;
            m_instr = '0;
            m_q.delete();
            foreach (m_flag[i]) m_flag[i] = 0;
        end else begin
            if (!m_busy && iReadEnable) begin
                m_valid = 1;
                m_instr = m_flag[iAddress] ? m_mem[iAddress] : DEF;
            end else begin
                m_valid = 0;
            end
            if (!m_busy) begin
                if (iLoadStart) begin
                    m_busy = 1;
                    m_ptr  = int'(iLoadBase);
                    m_left = int'(iLoadCount);
                    m_done = (m_left == 0);
                    m_q.delete();
                end
            end else if (m_done) begin
                m_busy = 0;
                m_done = 0;
            end else if (m_q.size() == BY) begin
                logic [DW-1:0] w;
                w = '0;
                foreach (m_q[i]) w = (w << 8) | DW'(m_q[i]);
                m_mem[m_ptr]  = w;
                m_flag[m_ptr] = 1;
                m_ptr  = (m_ptr + 1) % DEPTH;
                m_left = m_left - 1;
                m_q.delete();
                if (m_left == 0) m_done = 1;
            end else if (iByteValid) begin
                m_q.push_back(iByte);
            end
        end
    end

    always @(negedge Clock) begin
        if (m_init) begin
            chk("m_valid",   DW'(oValid),     DW'(m_valid));
            chk("m_instr",   oInstruction,    m_instr);
            chk("m_loading", DW'(oLoading),   DW'(m_busy));
            chk("m_done",    DW'(oLoadDone),  DW'(m_busy && m_done));
            chk("m_ready",   DW'(oByteReady), DW'(m_busy && !m_done && m_q.size() < BY));
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input int addr, input logic [DW-1:0] exp);
        iAddress    = AW'(addr);
        iReadEnable = 1'b1;
        step();
        iReadEnable = 1'b0;
        chk($sformatf("fetch_valid_%0d", addr), DW'(oValid), DW'(1));
        chk($sformatf("fetch_data_%0d", addr), oInstruction, exp);
    endtask

    task automatic start_load(input int base, input int count, output int t);
        t          = cyc;
        iLoadBase  = AW'(base);
        iLoadCount = (AW + 1)'(count);
        iLoadStart = 1'b1;
        step();
        iLoadStart = 1'b0;
        chk("start_loading", DW'(oLoading), DW'(1));
        chk("start_ready", DW'(oByteReady), DW'(count != 0));
    endtask

    task automatic send_word(input logic [DW-1:0] w, input bit gap);
        bit r;
        int n;
        for (int i = 0; i < BY; i++) begin
            if (gap) begin
                iByteValid = 1'b0;
                step();
            end
            iByte      = w[DW-1-8*i -: 8];
            iByteValid = 1'b1;
            n = 0;
            do begin
                r = oByteReady;
                step();
                n++;
            end while (!r && n < 20);
            chk("byte_accepted", DW'(r), DW'(1));
        end
        iByteValid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        while (!oLoadDone && n < 40) begin
            step();
            n++;
        end
        chk("done_seen", DW'(oLoadDone), DW'(1));
        dc = cyc;
        step();
        chk("idle_after_done", DW'(oLoading), DW'(0));
    endtask

    initial begin
        int t, dc;
        Reset = 1'b1;
        step();
        step();
        chk("rst_valid", DW'(oValid), DW'(0));
        chk("rst_instr", oInstruction, '0);
        chk("rst_ready", DW'(oByteReady), DW'(0));
        chk("rst_loading", DW'(oLoading), DW'(0));
        chk("rst_done", DW'(oLoadDone), DW'(0));
        Reset = 1'b0;

        // default read, then no request
        fetch(5, DEF);
        step();
        chk("noreq_valid", DW'(oValid), DW'(0));

        // two-word load, back-to-back bytes
        start_load(3, 2, t);
        send_word(32'h0102_0304, 1'b0);
        send_word(32'h0506_0708, 1'b0);
        wait_done(dc);
        chk("two_word_done_cycle", DW'(dc), DW'(t + 11));
        fetch(3, 32'h0102_0304);
        fetch(4, 32'h0506_0708);
        fetch(5, DEF);

        // wrap-around past the top address
        start_load(1023, 2, t);
        send_word(32'hAABB_CCDD, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        wait_done(dc);
        chk("wrap_done_cycle", DW'(dc), DW'(t + 11));
        fetch(1023, 32'hAABB_CCDD);
        fetch(0, 32'h1122_3344);
        fetch(1, DEF);

        // one idle cycle before every byte: done slips by four cycles
        start_load(9, 1, t);
        send_word(32'hC0FF_EE42, 1'b1);
        wait_done(dc);
        chk("gap_done_cycle", DW'(dc), DW'(t + 10));
        fetch(9, 32'hC0FF_EE42);

        // fetch and a second start during a load are both ignored
        fetch(3, 32'h0102_0304);
        start_load(20, 1, t);
        iAddress    = AW'(4);
        iReadEnable = 1'b1;
        iLoadBase   = AW'(30);
        iLoadCount  = '0;
        iLoadStart  = 1'b1;
        step();
        iReadEnable = 1'b0;
        iLoadStart  = 1'b0;
        chk("busy_fetch_valid", DW'(oValid), DW'(0));
        chk("busy_fetch_hold", oInstruction, 32'h0102_0304);
        send_word(32'h1234_5678, 1'b0);
        wait_done(dc);
        fetch(20, 32'h1234_5678);
        fetch(30, DEF);

        // zero-count load
        start_load(40, 0, t);
        chk("zero_done_pulse", DW'(oLoadDone), DW'(1));
        step();
        chk("zero_idle", DW'(oLoading), DW'(0));
        fetch(40, DEF);

        // reset after two bytes of a word
        start_load(3, 1, t);
        iByteValid = 1'b1;
        iByte = 8'hAA;
        step();
        iByte = 8'hBB;
        step();
        iByteValid = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("midrst_valid", DW'(oValid), DW'(0));
        chk("midrst_instr", oInstruction, '0);
        chk("midrst_ready", DW'(oByteReady), DW'(0));
        chk("midrst_loading", DW'(oLoading), DW'(0));
        chk("midrst_done", DW'(oLoadDone), DW'(0));
        fetch(3, DEF);
        fetch(20, DEF);
        start_load(7, 1, t);
        send_word(32'hCAFE_BABE, 1'b0);
        wait_done(dc);
        chk("post_rst_done_cycle", DW'(dc), DW'(t + 6));
        fetch(7, 32'hCAFE_BABE);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
